// File: rtl/replace_array_arbiter.sv
// Round-robin arbiter granting single-element replacements into a shared register array.
// Optional macro REPLACE_ARRAY_GRANT_COUNT_EN adds a 16-bit wrapping handshake counter output.
module replace_array_arbiter #(
  parameter int N_REQ  = 4,
  parameter int N_ELEM = 2,
  parameter int ELEM_W = 1,
  parameter int IDX_W  = 1,
  parameter logic [N_ELEM*ELEM_W-1:0] RESET_VALUE = {N_ELEM*ELEM_W{1'b1}}
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*IDX_W-1:0]   req_idx,
  input  logic [N_REQ*ELEM_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     freeze,
  output logic [N_ELEM*ELEM_W-1:0] O,
  output logic                     commit_valid,
  output logic [IDX_W-1:0]         commit_idx,
  output logic                     err
`ifdef REPLACE_ARRAY_GRANT_COUNT_EN
  ,
  output logic [15:0]              grant_count
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]          r_ptr;
  logic                      r_pend_valid;
  logic [IDX_W-1:0]          r_pend_idx;
  logic [ELEM_W-1:0]         r_pend_data;
  logic [N_ELEM*ELEM_W-1:0]  r_arr;
  logic                      r_commit_valid;
  logic [IDX_W-1:0]          r_commit_idx;
  logic                      r_err;

  logic [2*N_REQ-1:0]        w_dbl;
  logic [PTR_W:0]            w_sum;
  logic                      w_hs;
  logic [PTR_W-1:0]          w_grant_id;
  logic [PTR_W-1:0]          w_ptr_nxt;
  logic [N_REQ-1:0]          w_grant;
  logic [IDX_W-1:0]          w_sel_idx;
  logic [ELEM_W-1:0]         w_sel_data;
  logic                      w_in_range;

  // Rotate the request vector so bit 0 is the requester at the pointer.
  assign w_dbl = {req_valid, req_valid} >> r_ptr;

  always_comb begin
    w_hs       = 1'b0;
    w_sum      = '0;
    w_grant_id = '0;
    w_grant    = '0;
    if (!freeze && !RESET) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!w_hs && w_dbl[k]) begin
          w_hs  = 1'b1;
          w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
        end
      end
    end
    if (w_sum >= (PTR_W+1)'(N_REQ)) w_sum = w_sum - (PTR_W+1)'(N_REQ);
    w_grant_id = w_sum[PTR_W-1:0];
    if (w_hs) w_grant = N_REQ'(1) << w_grant_id;
  end

  always_comb begin
    w_sel_idx  = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_idx  = req_idx[i*IDX_W +: IDX_W];
        w_sel_data = req_data[i*ELEM_W +: ELEM_W];
      end
    end
  end

  assign w_ptr_nxt  = (w_grant_id == PTR_W'(N_REQ-1)) ? '0 : w_grant_id + 1'b1;
  assign w_in_range = (int'(r_pend_idx) < N_ELEM);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ptr          <= '0;
      r_pend_valid   <= 1'b0;
      r_pend_idx     <= '0;
      r_pend_data    <= '0;
      r_arr          <= RESET_VALUE;
      r_commit_valid <= 1'b0;
      r_commit_idx   <= '0;
      r_err          <= 1'b0;
    end else begin
      r_pend_valid   <= w_hs;
      r_commit_valid <= 1'b0;
      if (w_hs) begin
        r_ptr       <= w_ptr_nxt;
        r_pend_idx  <= w_sel_idx;
        r_pend_data <= w_sel_data;
      end
      // Retire the previously captured write; a new capture may happen in the same edge.
      if (r_pend_valid) begin
        if (w_in_range) begin
          for (int e = 0; e < N_ELEM; e++) begin
            if (int'(r_pend_idx) == e) r_arr[e*ELEM_W +: ELEM_W] <= r_pend_data;
          end
          r_commit_valid <= 1'b1;
          r_commit_idx   <= r_pend_idx;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

`ifdef REPLACE_ARRAY_GRANT_COUNT_EN
  logic [15:0] r_grant_count;

  always_ff @(posedge CLK) begin
    if (RESET)     r_grant_count <= '0;
    else if (w_hs) r_grant_count <= r_grant_count + 16'd1;
  end

  assign grant_count = r_grant_count;
`endif

  assign req_ready    = w_grant;
  assign O            = r_arr;
  assign commit_valid = r_commit_valid;
  assign commit_idx   = r_commit_idx;
  assign err          = r_err;

endmodule

// File: tb/tb_replace_array_arbiter.sv
// Testbench for replace_array_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_replace_array_arbiter;

  localparam int NR = 4;
  localparam int NE = 2;
  localparam int EW = 1;
  localparam int IW = 2;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [NR-1:0] req_valid;
  logic [NR*IW-1:0] req_idx;
  logic [NR*EW-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          freeze;
  logic [NE*EW-1:0] O;
  logic          commit_valid;
  logic [IW-1:0] commit_idx;
  logic          err;
`ifdef REPLACE_ARRAY_GRANT_COUNT_EN
  logic [15:0]   grant_count;
`endif

  replace_array_arbiter #(.N_REQ(NR), .N_ELEM(NE), .ELEM_W(EW), .IDX_W(IW)) dut (
    .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_idx(req_idx),
    .req_data(req_data), .req_ready(req_ready), .freeze(freeze), .O(O),
    .commit_valid(commit_valid), .commit_idx(commit_idx), .err(err)
`ifdef REPLACE_ARRAY_GRANT_COUNT_EN
    , .grant_count(grant_count)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct { int idx; int data; } wr_t;

  int n_tests = 0;
  int n_fail  = 0;

  int s_idx[NR];
  int s_data[NR];

  int m_o[NE];
  int m_ptr = 0;
  int m_cv = 0;
  int m_ci = 0;
  int m_err = 0;
  int m_cnt = 0;
  wr_t pq[$];

  int exp_g;
  logic [NR-1:0] exp_ready;
  logic [NR-1:0] obs_ready;

  function automatic logic [NE*EW-1:0] exp_o();
    logic [NE*EW-1:0] v;
    for (int e = 0; e < NE; e++) v[e] = m_o[e][0];
    return v;
  endfunction

  function automatic int onehot_id(input logic [NR-1:0] v);
    int r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Drive one clock cycle and advance the reference model across its rising edge.
  task automatic cycle(input logic [NR-1:0] v, input logic f, input logic r);
    int best;
    int d;
    wr_t w;
    req_valid = v;
    freeze    = f;
    RESET     = r;
    for (int i = 0; i < NR; i++) begin
      req_idx[i*IW +: IW]  = IW'(s_idx[i]);
      req_data[i*EW +: EW] = EW'(s_data[i]);
    end
    #1;
    exp_g = -1;
    best  = NR;
    if (!f && !r) begin
      for (int i = 0; i < NR; i++) begin
        d = (i - m_ptr + NR) % NR;
        if (v[i] && d < best) begin
          best  = d;
          exp_g = i;
        end
      end
    end
    exp_ready = (exp_g < 0) ? '0 : NR'(1 << exp_g);
    obs_ready = req_ready;
    @(posedge CLK);
    if (r) begin
      for (int e = 0; e < NE; e++) m_o[e] = 1;
      m_ptr = 0; m_cv = 0; m_ci = 0; m_err = 0; m_cnt = 0;
      pq.delete();
    end else begin
      m_cv = 0;
      if (pq.size() > 0) begin
        w = pq.pop_front();
        if (w.idx < NE) begin
          m_o[w.idx] = w.data;
          m_cv = 1;
          m_ci = w.idx;
        end else begin
          m_err = 1;
        end
      end
      if (exp_g >= 0) begin
        w.idx  = s_idx[exp_g];
        w.data = s_data[exp_g];
        pq.push_back(w);
        m_ptr = (exp_g + 1) % NR;
        m_cnt = m_cnt + 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      cycle(4'b1111, 1'b0, 1'b1);
      n_tests++;
      if (obs_ready !== 4'b0000) begin
        n_fail++; $display("FAIL reset_ready: got %b expected 0000", obs_ready);
      end
    end
    n_tests++;
    if (O !== 2'b11) begin n_fail++; $display("FAIL reset_O: got %b expected 11", O); end
    n_tests++;
    if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cv: got %b expected 0", commit_valid); end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_tests++;
    if (commit_idx !== 2'd0) begin n_fail++; $display("FAIL reset_ci: got %0d expected 0", commit_idx); end
`ifdef REPLACE_ARRAY_GRANT_COUNT_EN
    n_tests++;
    if (grant_count !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", grant_count); end
`endif
  endtask

  task automatic test_single_write();
    s_idx[0] = 1; s_data[0] = 0;
    cycle(4'b0001, 1'b0, 1'b0);
    n_tests++;
    if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected 0001", obs_ready); end
    n_tests++;
    if (O !== 2'b11 || commit_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_latency: got O=%b cv=%b expected O=11 cv=0", O, commit_valid);
    end
    cycle(4'b0000, 1'b0, 1'b0);
    n_tests++;
    if (O !== 2'b01) begin n_fail++; $display("FAIL single_O: got %b expected 01", O); end
    n_tests++;
    if (commit_valid !== 1'b1 || commit_idx !== 2'd1) begin
      n_fail++; $display("FAIL single_commit: got cv=%b idx=%0d expected cv=1 idx=1", commit_valid, commit_idx);
    end
    cycle(4'b0000, 1'b0, 1'b0);
    n_tests++;
    if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL single_cv_drop: got %b expected 0", commit_valid); end
  endtask

  task automatic test_round_robin();
    int wins[NR];
    int g;
    cycle(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < NR; i++) begin
      wins[i] = 0; s_idx[i] = $urandom_range(0, 1); s_data[i] = $urandom_range(0, 1);
    end
    for (int k = 0; k < 8; k++) begin
      cycle(4'b1111, 1'b0, 1'b0);
      g = onehot_id(obs_ready);
      n_tests++;
      if (obs_ready !== NR'(1 << (k % NR))) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b expected id %0d", k, obs_ready, k % NR);
      end
      if (g >= 0) begin
        wins[g]++;
        s_idx[g] = $urandom_range(0, 1); s_data[g] = $urandom_range(0, 1);
      end
    end
    for (int i = 0; i < NR; i++) begin
      n_tests++;
      if (wins[i] != 2) begin n_fail++; $display("FAIL rr_wins[%0d]: got %0d expected 2", i, wins[i]); end
    end
    cycle(4'b0000, 1'b0, 1'b0);
    n_tests++;
    if (O !== exp_o()) begin n_fail++; $display("FAIL rr_O: got %b expected %b", O, exp_o()); end
  endtask

  task automatic test_freeze();
    cycle(4'b0000, 1'b0, 1'b1);
    s_idx[1] = 0; s_data[1] = 0; s_idx[3] = 1; s_data[3] = 0;
    cycle(4'b1010, 1'b0, 1'b0);
    n_tests++;
    if (obs_ready !== 4'b0010) begin n_fail++; $display("FAIL frz_first: got %b expected 0010", obs_ready); end
    s_idx[1] = 1; s_data[1] = 1;
    for (int k = 0; k < 3; k++) begin
      cycle(4'b1010, 1'b1, 1'b0);
      n_tests++;
      if (obs_ready !== 4'b0000) begin n_fail++; $display("FAIL frz_ready[%0d]: got %b expected 0000", k, obs_ready); end
      if (k == 0) begin
        n_tests++;
        if (commit_valid !== 1'b1 || O !== 2'b10) begin
          n_fail++; $display("FAIL frz_pend_commit: got cv=%b O=%b expected cv=1 O=10", commit_valid, O);
        end
      end
    end
    cycle(4'b1010, 1'b0, 1'b0);
    n_tests++;
    if (obs_ready !== 4'b1000) begin n_fail++; $display("FAIL frz_release: got %b expected 1000", obs_ready); end
    cycle(4'b0010, 1'b0, 1'b0);
    n_tests++;
    if (obs_ready !== 4'b0010) begin n_fail++; $display("FAIL frz_then1: got %b expected 0010", obs_ready); end
    cycle(4'b0000, 1'b0, 1'b0);
    n_tests++;
    if (O !== 2'b10 || O !== exp_o()) begin n_fail++; $display("FAIL frz_O: got %b expected 10", O); end
  endtask

  task automatic test_out_of_range();
    cycle(4'b0000, 1'b0, 1'b1);
    s_idx[0] = 3; s_data[0] = 0;
    cycle(4'b0001, 1'b0, 1'b0);
    n_tests++;
    if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL oor_accept: got %b expected 0001", obs_ready); end
    cycle(4'b0000, 1'b0, 1'b0);
    n_tests++;
    if (O !== 2'b11 || commit_valid !== 1'b0 || err !== 1'b1) begin
      n_fail++; $display("FAIL oor_commit: got O=%b cv=%b err=%b expected O=11 cv=0 err=1", O, commit_valid, err);
    end
    for (int k = 0; k < 3; k++) cycle(4'b0000, 1'b0, 1'b0);
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL oor_sticky: got %b expected 1", err); end
    s_idx[0] = 0; s_data[0] = 0;
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b1);
    n_tests++;
    if (O !== 2'b11 || err !== 1'b0 || commit_valid !== 1'b0) begin
      n_fail++; $display("FAIL midop_reset: got O=%b err=%b cv=%b expected O=11 err=0 cv=0", O, err, commit_valid);
    end
    cycle(4'b0000, 1'b0, 1'b0);
    n_tests++;
    if (O !== 2'b11 || commit_valid !== 1'b0) begin
      n_fail++; $display("FAIL midop_discard: got O=%b cv=%b expected O=11 cv=0", O, commit_valid);
    end
  endtask

  task automatic test_back_to_back();
    cycle(4'b0000, 1'b0, 1'b1);
    s_idx[0] = 0; s_data[0] = 0; s_idx[1] = 0; s_data[1] = 1;
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0010, 1'b0, 1'b0);
    n_tests++;
    if (obs_ready !== 4'b0010) begin n_fail++; $display("FAIL b2b_grant: got %b expected 0010", obs_ready); end
    n_tests++;
    if (O !== 2'b10 || commit_valid !== 1'b1 || commit_idx !== 2'd0) begin
      n_fail++; $display("FAIL b2b_first: got O=%b cv=%b idx=%0d expected O=10 cv=1 idx=0", O, commit_valid, commit_idx);
    end
    cycle(4'b0000, 1'b0, 1'b0);
    n_tests++;
    if (O !== 2'b11 || commit_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second: got O=%b cv=%b expected O=11 cv=1", O, commit_valid);
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] v;
    logic f;
    cycle(4'b0000, 1'b0, 1'b1);
    v = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NR; i++) begin
        if (v[i] && $urandom_range(0, 9) == 0) v[i] = 1'b0;
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i] = 1'b1;
          s_idx[i]  = ($urandom_range(0, 49) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1);
          s_data[i] = $urandom_range(0, 1);
        end
      end
      f = ($urandom_range(0, 6) == 0);
      cycle(v, f, 1'b0);
      n_tests++;
      if (obs_ready !== exp_ready) begin
        n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", k, obs_ready, exp_ready);
      end
      if (exp_g >= 0) v[exp_g] = 1'b0;
      n_tests++;
      if (O !== exp_o() || commit_valid !== m_cv[0] || err !== m_err[0]) begin
        n_fail++; $display("FAIL rnd_state[%0d]: got O=%b cv=%b err=%b expected O=%b cv=%0d err=%0d",
                           k, O, commit_valid, err, exp_o(), m_cv, m_err);
      end
      if (m_cv == 1) begin
        n_tests++;
        if (commit_idx !== IW'(m_ci)) begin
          n_fail++; $display("FAIL rnd_cidx[%0d]: got %0d expected %0d", k, commit_idx, m_ci);
        end
      end
    end
  endtask

`ifdef REPLACE_ARRAY_GRANT_COUNT_EN
  task automatic test_grant_count();
    cycle(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < NR; i++) begin s_idx[i] = i; s_data[i] = 0; end
    for (int k = 0; k < 70000; k++) cycle(4'b1111, 1'b0, 1'b0);
    n_tests++;
    if (grant_count !== 16'd4464 || grant_count !== 16'(m_cnt)) begin
      n_fail++; $display("FAIL grant_count: got %0d expected 4464", grant_count);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < NR; i++) begin s_idx[i] = 0; s_data[i] = 0; end
    for (int e = 0; e < NE; e++) m_o[e] = 1;
    req_valid = '0; req_idx = '0; req_data = '0; freeze = 1'b0; RESET = 1'b1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_freeze();
    test_out_of_range();
    test_back_to_back();
    test_random();
`ifdef REPLACE_ARRAY_GRANT_COUNT_EN
    test_grant_count();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
